unsigned_square_pipe: RTL and testbench



---
 rtl/usq_pkg.sv | 22 ++
 rtl/usq_mul_pipe.sv | 42 ++++
 rtl/unsigned_square_pipe.sv | 161 ++++++++++++++++
 tb/tb_unsigned_square_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usq_pkg.sv
// rtl/usq_pkg.sv - shared types and width helpers for the unsigned squarer pipeline.
package usq_pkg;

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_ACC    = 1'b1
    } usq_mode_e;

    typedef struct packed {
        logic      valid;
        usq_mode_e mode;
        logic      eof;
    } usq_sb_t;

    localparam int SB_W = $bits(usq_sb_t);

    // Result width: full product plus enough headroom for a whole accumulate frame.
    function automatic int usq_out_w(input int data_w, input int acc_len);
        return 2 * data_w + $clog2(acc_len);
    endfunction

endpackage

// File: rtl/usq_mul_pipe.sv
// rtl/usq_mul_pipe.sv - LAT-stage unsigned squarer with a shared enable and sideband.
module usq_mul_pipe
    import usq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LAT    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [SB_W-1:0]       sb_i,
    output logic [2*DATA_W-1:0]   prod_o,
    output logic [SB_W-1:0]       sb_o
);

    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] prod_q [LAT];
    logic [SB_W-1:0]     sb_q   [LAT];

    assign a_ext = {{DATA_W{1'b0}}, a_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                prod_q[i] <= '0;
                sb_q[i]   <= '0;
            end
        end else if (en_i) begin
            prod_q[0] <= a_ext * a_ext;
            sb_q[0]   <= sb_i;
            for (int i = 1; i < LAT; i++) begin
                prod_q[i] <= prod_q[i-1];
                sb_q[i]   <= sb_q[i-1];
            end
        end
    end

    assign prod_o = prod_q[LAT-1];
    assign sb_o   = sb_q[LAT-1];

endmodule

// File: rtl/unsigned_square_pipe.sv
// rtl/unsigned_square_pipe.sv - pipelined unsigned squarer with stream handshake.
// Sum-of-squares frame mode is built only when USQ_ACC_EN is defined.
module unsigned_square_pipe
    import usq_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int LAT     = 3,
    parameter  int ACC_LEN = 16,
    localparam int OUT_W   = usq_out_w(DATA_W, ACC_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [OUT_W-1:0]  data_o,
    output logic              out_last_o
);

    logic                en;
    logic                accept;
    logic                eof;
    usq_mode_e           cur_mode;
    logic [DATA_W-1:0]   a_q;
    usq_sb_t             sb_in_q, sb_in_d, sb_out;
    logic [2*DATA_W-1:0] prod;
    logic [OUT_W-1:0]    prod_ext;
    logic [OUT_W-1:0]    data_q, data_d;
    logic                out_valid_q, out_valid_d;
    logic                last_q, last_d;

    assign en         = !out_valid_q | out_ready_i;
    assign in_ready_o = en;
    assign accept     = in_valid_i & en;

`ifdef USQ_ACC_EN
    localparam int CNT_W = $clog2(ACC_LEN);

    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic             open_q, open_d;
    usq_mode_e        mode_q, mode_d;
    logic [OUT_W-1:0] acc_q, acc_d;

    // Mode is frozen from the first beat of a frame until its eof beat.
    assign cur_mode = open_q ? mode_q : usq_mode_e'(mode_i);
    assign eof      = last_i | (cur_mode == MODE_ACC && in_cnt_q == CNT_W'(ACC_LEN - 1));

    always_comb begin
        in_cnt_d = in_cnt_q;
        open_d   = open_q;
        mode_d   = mode_q;
        if (accept) begin
            open_d = !eof;
            mode_d = cur_mode;
            if (cur_mode == MODE_ACC) begin
                in_cnt_d = eof ? '0 : in_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt_q <= '0;
            open_q   <= 1'b0;
            mode_q   <= MODE_SQUARE;
            acc_q    <= '0;
        end else begin
            in_cnt_q <= in_cnt_d;
            open_q   <= open_d;
            mode_q   <= mode_d;
            acc_q    <= acc_d;
        end
    end
`else
    logic [1:0] unused_mode;

    assign cur_mode    = MODE_SQUARE;
    assign eof         = last_i;
    assign unused_mode = {mode_i, sb_out.mode};
`endif

    assign sb_in_d = '{valid: accept, mode: cur_mode, eof: eof};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            sb_in_q <= '0;
        end else if (en) begin
            a_q     <= data_i;
            sb_in_q <= sb_in_d;
        end
    end

    usq_mul_pipe #(
        .DATA_W (DATA_W),
        .LAT    (LAT)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (en),
        .a_i    (a_q),
        .sb_i   (sb_in_q),
        .prod_o (prod),
        .sb_o   (sb_out)
    );

    assign prod_ext = OUT_W'(prod);

    // With en high the current result is either absent or being taken, so valid drops unless reloaded.
    always_comb begin
        data_d      = data_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
`ifdef USQ_ACC_EN
        acc_d       = acc_q;
`endif
        if (en) begin
            out_valid_d = 1'b0;
            if (sb_out.valid) begin
`ifdef USQ_ACC_EN
                if (sb_out.mode == MODE_ACC) begin
                    if (sb_out.eof) begin
                        data_d      = acc_q + prod_ext;
                        acc_d       = '0;
                        last_d      = 1'b1;
                        out_valid_d = 1'b1;
                    end else begin
                        acc_d = acc_q + prod_ext;
                    end
                end else
`endif
                begin
                    data_d      = prod_ext;
                    last_d      = sb_out.eof;
                    out_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '0;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    assign data_o      = data_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = last_q;

endmodule

// File: tb/tb_unsigned_square_pipe.sv
// tb/tb_unsigned_square_pipe.sv - directed self-checking bench for unsigned_square_pipe.
module tb_unsigned_square_pipe;

    localparam int DATA_W  = 8;
    localparam int LAT     = 3;
    localparam int ACC_LEN = 4;
    localparam int OUT_W   = 18;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              m;
        logic              l;
        logic [OUT_W-1:0]  exp_d;
        logic              exp_l;
    } vec_t;

    typedef struct {
        logic [OUT_W-1:0] d;
        logic             l;
        int               c;
    } obs_t;

    typedef struct {
        logic [OUT_W-1:0] d;
        logic             l;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             mode_i = 1'b0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [DATA_W-1:0] data_i = '0;
    logic             last_i = 1'b0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b1;
    logic [OUT_W-1:0] data_o;
    logic             out_last_o;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   rdy_low = 0;
    int   acc_cyc;
    int   first_cyc;
    obs_t obs_q[$];
    exp_t exp_q[$];
    vec_t sq_tab[5];

    unsigned_square_pipe #(
        .DATA_W  (DATA_W),
        .LAT     (LAT),
        .ACC_LEN (ACC_LEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode_i      (mode_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .data_i      (data_i),
        .last_i      (last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .data_o      (data_o),
        .out_last_o  (out_last_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && out_valid_o && out_ready_i) obs_q.push_back('{data_o, out_last_o, cyc});
        if (rst_n && !in_ready_o) rdy_low++;
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic beat(input logic [DATA_W-1:0] d, input logic m, input logic l);
        logic ok;
        int   guard;
        ok    = 1'b0;
        guard = 0;
        data_i = d; mode_i = m; last_i = l; in_valid_i = 1'b1;
        while (!ok && guard < 50) begin
            @(negedge clk);
            ok = in_ready_o;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!ok) check("beat_accept_timeout", 0, 1);
        acc_cyc    = cyc;
        in_valid_i = 1'b0;
        last_i     = 1'b0;
    endtask

    task automatic drain();
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [OUT_W-1:0] d, input logic l);
        exp_q.push_back('{d, l});
    endtask

    task automatic compare_q(input string name);
        check({name, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s_data%0d", name, i), obs_q[i].d, exp_q[i].d);
            check($sformatf("%s_last%0d", name, i), obs_q[i].l, exp_q[i].l);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        sq_tab[0] = '{8'd0,   1'b0, 1'b0, 18'd0,     1'b0};
        sq_tab[1] = '{8'd1,   1'b0, 1'b0, 18'd1,     1'b0};
        sq_tab[2] = '{8'd2,   1'b0, 1'b0, 18'd4,     1'b0};
        sq_tab[3] = '{8'd3,   1'b0, 1'b0, 18'd9,     1'b0};
        sq_tab[4] = '{8'd255, 1'b0, 1'b1, 18'd65025, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_last", out_last_o, 0);
        check("rst_in_ready", in_ready_o, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Back-to-back squares, first result LAT+1 cycles after accept
        obs_q.delete();
        for (int i = 0; i < 5; i++) begin
            beat(sq_tab[i].d, sq_tab[i].m, sq_tab[i].l);
            if (i == 0) first_cyc = acc_cyc;
            push_exp(sq_tab[i].exp_d, sq_tab[i].exp_l);
        end
        drain();
        if (obs_q.size() == 5) begin
            check("sq_first_latency", obs_q[0].c - first_cyc, 4);
            check("sq_consecutive", obs_q[4].c - obs_q[0].c, 4);
        end
        compare_q("square");

        // Output stall of 5 cycles mid-stream
        rdy_low = 0;
        fork
            begin
                for (int i = 1; i <= 10; i++) begin
                    beat(DATA_W'(i), 1'b0, i == 10);
                    push_exp(OUT_W'(i * i), i == 10);
                end
            end
            begin
                repeat (7) @(posedge clk);
                #1 out_ready_i = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready_i = 1'b1;
            end
        join
        drain();
        check("stall_in_ready_low", rdy_low, 5);
        compare_q("stall");

`ifdef USQ_ACC_EN
        // Frame closed by the beat counter
        for (int i = 1; i <= 4; i++) beat(DATA_W'(i), 1'b1, 1'b0);
        first_cyc = acc_cyc;
        push_exp(18'd30, 1'b1);
        drain();
        if (obs_q.size() == 1) check("acc_latency", obs_q[0].c - first_cyc, 4);
        compare_q("acc_count");

        // last_i closes a short frame, then a full-length frame of maxima
        beat(8'd255, 1'b1, 1'b0);
        beat(8'd255, 1'b1, 1'b1);
        push_exp(18'd130050, 1'b1);
        for (int i = 0; i < 4; i++) beat(8'd255, 1'b1, 1'b0);
        push_exp(18'd260100, 1'b1);
        drain();
        compare_q("acc_max");

        // mode_i changes mid-frame are ignored
        beat(8'd1, 1'b1, 1'b0);
        beat(8'd1, 1'b1, 1'b0);
        beat(8'd1, 1'b0, 1'b0);
        beat(8'd1, 1'b0, 1'b0);
        push_exp(18'd4, 1'b1);
        beat(8'd5, 1'b0, 1'b0);
        beat(8'd6, 1'b0, 1'b0);
        push_exp(18'd25, 1'b0);
        push_exp(18'd36, 1'b0);
        drain();
        compare_q("acc_mode_latch");
`else
        for (int i = 1; i <= 4; i++) begin
            beat(DATA_W'(i), 1'b1, 1'b0);
            push_exp(OUT_W'(i * i), 1'b0);
        end
        drain();
        compare_q("noacc_squares");

        beat(8'd255, 1'b1, 1'b1);
        push_exp(18'd65025, 1'b1);
        beat(8'd6, 1'b1, 1'b0);
        push_exp(18'd36, 1'b0);
        drain();
        compare_q("noacc_last");
`endif

        // Reset mid-frame discards the partial frame
        beat(8'd7, 1'b1, 1'b0);
        beat(8'd7, 1'b1, 1'b0);
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("midrst_out_valid", out_valid_o, 0);
            check("midrst_data", data_o, 0);
            check("midrst_in_ready", in_ready_o, 1);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        obs_q.delete();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) beat(8'd1, 1'b1, 1'b0);
`ifdef USQ_ACC_EN
        push_exp(18'd4, 1'b1);
`else
        for (int i = 0; i < 4; i++) push_exp(18'd1, 1'b0);
`endif
        drain();
        compare_q("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
